div32_seq: RTL and testbench

- Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage beside the combinational 32-bit adder/subtractor.
- Where the adder computes A±B in one pass, this block inverts multiplication by iterated 33-bit restoring subtraction, one quotient bit per cycle.
- The pipeline control stalls EX while o_busy is high and flushes the block via i_kill.

---
 rtl/div32_seq.sv | 175 +++++++++++++++++
 tb/tb_div32_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): restoring division producing
// one quotient bit per cycle, fixed 33-cycle latency from acceptance to o_valid.
module div32_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_kill,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] r_q, r_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            last_step;
  logic            in_signed;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] r_step, q_step;
  logic [XLEN-1:0] result_sel;

  // op[0]=1 selects unsigned, op[1]=1 selects remainder
  assign accept    = (state_q == S_IDLE) && i_start && !i_kill;
  assign last_step = (state_q == S_CALC) && (cnt_q == LAST_CNT);
  assign in_signed = !i_op[0];
  assign a_abs     = (in_signed && i_a[XLEN-1]) ? -i_a : i_a;
  assign b_abs     = (in_signed && i_b[XLEN-1]) ? -i_b : i_b;

  // One restoring step: trial-subtract the divisor from the shifted remainder
  always_comb begin
    diff = {r_q, q_q[XLEN-1]} - {1'b0, b_q};
    if (!diff[XLEN]) begin
      r_step = diff[XLEN-1:0];
      q_step = {q_q[XLEN-2:0], 1'b1};
    end else begin
      r_step = {r_q[XLEN-2:0], q_q[XLEN-1]};
      q_step = {q_q[XLEN-2:0], 1'b0};
    end
  end

  // Final result from the last step's values, special cases first
  always_comb begin
    result_sel = q_step;
    if (div0_q) begin
      result_sel = op_q[1] ? a_q : '1;
    end else if (ovf_q) begin
      result_sel = op_q[1] ? '0 : MIN_NEG;
    end else if (op_q[1]) begin
      result_sel = neg_r_q ? -r_step : r_step;
    end else begin
      result_sel = neg_q_q ? -q_step : q_step;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (i_start)   state_d = S_CALC;
        S_CALC:  if (last_step) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      S_IDLE:  o_ready = 1'b1;
      S_CALC:  o_busy  = 1'b1;
      S_DONE: begin
        o_busy  = 1'b1;
        o_valid = !i_kill;
      end
      default: o_ready = 1'b0;
    endcase
  end

  // Datapath: latch operands on acceptance, iterate in CALC; frozen by kill
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    if (accept) begin
      op_d    = i_op;
      a_d     = i_a;
      b_d     = b_abs;
      q_d     = a_abs;
      r_d     = '0;
      cnt_d   = '0;
      neg_q_d = in_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
      neg_r_d = in_signed && i_a[XLEN-1];
      div0_d  = (i_b == '0);
      ovf_d   = in_signed && (i_a == MIN_NEG) && (i_b == '1);
    end else if ((state_q == S_CALC) && !i_kill) begin
      r_d   = r_step;
      q_d   = q_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_step) result_d = result_sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq: latency, signed/unsigned results,
// divide-by-zero, overflow, kill, mid-operation reset and request spacing.
module tb_div32_seq;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_kill;
  logic [1:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        o_ready, o_busy, o_valid;
  logic [31:0] o_result;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_exp = 32'h0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  div32_seq dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_kill(i_kill), .o_ready(o_ready), .o_busy(o_busy),
    .o_valid(o_valid), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  // Called at a negedge; returns at the negedge of cycle T+1 with scrambled operands
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0; i_op = 2'($urandom); i_a = $urandom; i_b = $urandom;
  endtask

  // Observes o_valid for ncyc cycles starting at cycle T+1 (k=1)
  task automatic wait_valid(input int ncyc, output int lat, output logic [31:0] res, output int nv);
    lat = -1; res = 32'hx; nv = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (o_valid === 1'b1) begin
        nv++;
        if (lat < 0) begin lat = k; res = o_result; end
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 1'b0; i_kill = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", o_result); end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_unsigned();
    int lat, nv, ready_bad, busy_bad;
    logic [31:0] res;
    logic        ready34;
    issue(OP_DIVU, 32'd100, 32'd7);
    lat = -1; nv = 0; ready_bad = 0; busy_bad = 0; res = 'x; ready34 = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (o_valid === 1'b1) begin nv++; if (lat < 0) begin lat = k; res = o_result; end end
      if (k <= 33 && o_ready !== 1'b0) ready_bad++;
      if (k <= 33 && o_busy !== 1'b1) busy_bad++;
      if (k == 34) ready34 = o_ready;
      @(negedge i_clk);
    end
    checks++; if (lat != 33) begin failures++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu_result got=%h exp=%h", res, 32'd14); end
    checks++; if (nv != 1) begin failures++; $display("FAIL divu_valid_count got=%0d exp=1", nv); end
    checks++; if (ready_bad != 0) begin failures++; $display("FAIL divu_ready_low got=%0d_bad_cycles exp=0", ready_bad); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL divu_busy_high got=%0d_bad_cycles exp=0", busy_bad); end
    checks++; if (ready34 !== 1'b1) begin failures++; $display("FAIL divu_ready_T34 got=%b exp=1", ready34); end
    checks++; if (o_result !== 32'd14) begin failures++; $display("FAIL divu_result_hold got=%h exp=%h", o_result, 32'd14); end
    issue(OP_REMU, 32'd100, 32'd7);
    wait_valid(40, lat, res, nv);
    checks++; if (lat != 33 || res !== 32'd2) begin failures++; $display("FAIL remu got=%h@%0d exp=%h@33", res, lat, 32'd2); end
    last_exp = 32'd2;
  endtask

  task automatic test_signed();
    vec_t v[4];
    int lat, nv;
    logic [31:0] res;
    v[0] = '{OP_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    v[1] = '{OP_REM, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    v[2] = '{OP_REM, 32'd7,        32'hFFFFFFFE, 32'd1};
    v[3] = '{OP_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
    for (int i = 0; i < 4; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_valid(40, lat, res, nv);
      checks++;
      if (lat != 33 || nv != 1 || res !== v[i].exp) begin
        failures++;
        $display("FAIL signed_%0d got=%h@%0d(n=%0d) exp=%h@33", i, res, lat, nv, v[i].exp);
      end
      last_exp = v[i].exp;
    end
  endtask

  task automatic test_div0();
    vec_t v[4];
    int lat, nv;
    logic [31:0] res;
    v[0] = '{OP_DIVU, 32'd5,        32'd0, 32'hFFFFFFFF};
    v[1] = '{OP_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF};
    v[2] = '{OP_REMU, 32'd5,        32'd0, 32'd5};
    v[3] = '{OP_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB};
    for (int i = 0; i < 4; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_valid(40, lat, res, nv);
      checks++;
      if (lat != 33 || nv != 1 || res !== v[i].exp) begin
        failures++;
        $display("FAIL div0_%0d got=%h@%0d(n=%0d) exp=%h@33", i, res, lat, nv, v[i].exp);
      end
      last_exp = v[i].exp;
    end
  endtask

  task automatic test_ovf();
    vec_t v[3];
    int lat, nv;
    logic [31:0] res;
    v[0] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    v[1] = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0};
    v[2] = '{OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 3; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_valid(40, lat, res, nv);
      checks++;
      if (lat != 33 || nv != 1 || res !== v[i].exp) begin
        failures++;
        $display("FAIL ovf_%0d got=%h@%0d(n=%0d) exp=%h@33", i, res, lat, nv, v[i].exp);
      end
      last_exp = v[i].exp;
    end
  endtask

  task automatic test_kill_reset();
    int lat, nv;
    logic [31:0] res;
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge i_clk);
    i_kill = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0;
    checks++; if (o_ready !== 1'b1 || o_busy !== 1'b0) begin failures++; $display("FAIL kill_idle got=ready%b_busy%b exp=ready1_busy0", o_ready, o_busy); end
    checks++; if (o_result !== last_exp) begin failures++; $display("FAIL kill_result_hold got=%h exp=%h", o_result, last_exp); end
    wait_valid(40, lat, res, nv);
    checks++; if (nv != 0) begin failures++; $display("FAIL kill_no_valid got=%0d exp=0", nv); end
    issue(OP_DIVU, 32'hFFFFFFFF, 32'd1);
    wait_valid(40, lat, res, nv);
    checks++; if (lat != 33 || res !== 32'hFFFFFFFF) begin failures++; $display("FAIL after_kill got=%h@%0d exp=ffffffff@33", res, lat); end
    issue(OP_DIVU, 32'd12345, 32'd5);
    repeat (19) @(negedge i_clk);
    i_reset = 1'b1; i_kill = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0; i_kill = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_result !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset got=r%b_b%b_v%b_%h exp=r1_b0_v0_00000000", o_ready, o_busy, o_valid, o_result);
    end
    wait_valid(40, lat, res, nv);
    checks++; if (nv != 0) begin failures++; $display("FAIL reset_no_valid got=%0d exp=0", nv); end
    last_exp = 32'h0;
  endtask

  task automatic test_start_while_busy();
    int lat, nv;
    logic [31:0] res;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (4) @(negedge i_clk);
    i_start = 1'b1; i_op = OP_DIVU; i_a = 32'd1000; i_b = 32'd10;
    @(negedge i_clk);
    i_start = 1'b0;
    lat = -1; nv = 0; res = 'x;
    for (int k = 6; k <= 80; k++) begin
      if (o_valid === 1'b1) begin nv++; if (lat < 0) begin lat = k; res = o_result; end end
      @(negedge i_clk);
    end
    checks++; if (lat != 33 || res !== 32'hFFFFFFFD) begin failures++; $display("FAIL busy_start got=%h@%0d exp=fffffffd@33", res, lat); end
    checks++; if (nv != 1) begin failures++; $display("FAIL busy_start_valids got=%0d exp=1", nv); end
    last_exp = 32'hFFFFFFFD;
  endtask

  task automatic test_back_to_back();
    int lat, nv;
    logic [31:0] res;
    issue(OP_REMU, 32'd1000, 32'd7);
    repeat (32) @(negedge i_clk);
    i_start = 1'b1; i_op = OP_DIVU; i_a = 32'd1000; i_b = 32'd7;
    checks++; if (o_valid !== 1'b1 || o_result !== 32'd6) begin failures++; $display("FAIL b2b_first got=v%b_%h exp=v1_00000006", o_valid, o_result); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL b2b_done_ready got=%b exp=0", o_ready); end
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_ready got=%b exp=1", o_ready); end
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    wait_valid(40, lat, res, nv);
    checks++; if (lat != 33 || nv != 1 || res !== 32'd142) begin failures++; $display("FAIL b2b_second got=%h@%0d(n=%0d) exp=0000008e@33", res, lat, nv); end
    last_exp = 32'd142;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div0();
    test_ovf();
    test_kill_reset();
    test_start_while_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
